multi_digit_rate_counter: RTL and testbench

Parametrised successor to the single-digit rate divider / display counter / seven-segment chain. Holds a DIGITS-wide prescaler-driven up/down counter in a configurable radix, with synchronous load, a carry/borrow chain across digits, a one-cycle tick and wrap flags. It drives active-low seven-segment outputs for every digit. It sits between the board clock and the HEX displays, and is also used as a timebase for other blocks.

---
 rtl/multi_digit_rate_counter.sv | 142 ++++++++++++++
 tb/tb_multi_digit_rate_counter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_rate_counter.sv
// Prescaled multi-digit up/down counter in a configurable radix with seven-segment outputs.
// Define COUNT_DOWN_EN to honour the up port; otherwise the block always counts up.
module multi_digit_rate_counter #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned RADIX    = 10,
   parameter int unsigned PERIOD_W = 28
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [PERIOD_W-1:0]   period,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tick,
   output logic                  wrap,
   output logic [7*DIGITS-1:0]   seg
);

   localparam logic [3:0] DMAX = 4'(RADIX - 1);

   logic [PERIOD_W-1:0] div_q;
   logic [4*DIGITS-1:0] count_q;
   logic                tick_q;
   logic                wrap_q;
   logic [4*DIGITS-1:0] count_up;
   logic [4*DIGITS-1:0] count_step;
   logic [4*DIGITS-1:0] load_clamped;
   logic                all_max;
   logic                step_wraps;

   // Carry ripples only through digits sitting at RADIX-1.
   always_comb begin : inc_chain
      logic carry;
      count_up = count_q;
      carry    = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (carry) begin
            count_up[4*i +: 4] = (count_q[4*i +: 4] == DMAX) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
         end
         carry = carry && (count_q[4*i +: 4] == DMAX);
      end
      all_max = carry;
   end

`ifdef COUNT_DOWN_EN
   logic [4*DIGITS-1:0] count_dn;
   logic                all_zero;

   always_comb begin : dec_chain
      logic borrow;
      count_dn = count_q;
      borrow   = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (borrow) begin
            count_dn[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? DMAX : count_q[4*i +: 4] - 4'd1;
         end
         borrow = borrow && (count_q[4*i +: 4] == 4'd0);
      end
      all_zero = borrow;
   end

   assign count_step = up ? count_up : count_dn;
   assign step_wraps = up ? all_max : all_zero;
`else
   logic unused_up;
   assign unused_up  = up;
   assign count_step = count_up;
   assign step_wraps = all_max;
`endif

   // 5-bit compare keeps RADIX=16 from becoming a constant-false 4-bit test.
   always_comb begin
      load_clamped = load_value;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if ({1'b0, load_value[4*i +: 4]} > 5'(RADIX - 1)) begin
            load_clamped[4*i +: 4] = DMAX;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q   <= period;
         count_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else if (load) begin
         div_q   <= period;
         count_q <= load_clamped;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else if (enable) begin
         if (div_q == '0) begin
            div_q   <= period;
            count_q <= count_step;
            tick_q  <= 1'b1;
            wrap_q  <= step_wraps;
         end else begin
            div_q  <= div_q - 1'b1;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
         end
      end else begin
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end
   end

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   for (genvar g = 0; g < int'(DIGITS); g++) begin : gen_seg
      assign seg[7*g +: 7] = seg_of(count_q[4*g +: 4]);
   end

   assign count = count_q;
   assign tick  = tick_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_multi_digit_rate_counter.sv
// Scoreboard bench: two counter instances (radix 10 x2 digits, radix 16 x3 digits) against an
// integer-valued reference model.
module tb_multi_digit_rate_counter;

   localparam int PW = 8;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          up = 1'b1;
   logic          load = 1'b0;
   logic [PW-1:0] period = 8'd3;
   logic [11:0]   lv = '0;

   logic [7:0]  count0;
   logic        tick0, wrap0;
   logic [13:0] seg0;
   logic [11:0] count1;
   logic        tick1, wrap1;
   logic [20:0] seg1;

   always #5 clk = ~clk;

   multi_digit_rate_counter #(.DIGITS(2), .RADIX(10), .PERIOD_W(PW)) u0 (
      .clk(clk), .reset(reset), .enable(enable), .period(period), .up(up), .load(load),
      .load_value(lv[7:0]), .count(count0), .tick(tick0), .wrap(wrap0), .seg(seg0));

   multi_digit_rate_counter #(.DIGITS(3), .RADIX(16), .PERIOD_W(PW)) u1 (
      .clk(clk), .reset(reset), .enable(enable), .period(period), .up(up), .load(load),
      .load_value(lv), .count(count1), .tick(tick1), .wrap(wrap1), .seg(seg1));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each counter is a plain integer modulo RADIX**DIGITS.
   int radix [2] = '{10, 16};
   int ndig  [2] = '{2, 3};
   int val [2];
   int phase [2];
   int interval [2];
   logic mtick [2];
   logic mwrap [2];

   typedef struct packed {
      logic [11:0] c0; logic t0; logic w0;
      logic [11:0] c1; logic t1; logic w1;
   } exp_t;
   exp_t exp_q [$];

   function automatic int modulus(input int k);
      int m = 1;
      for (int i = 0; i < ndig[k]; i++) m *= radix[k];
      return m;
   endfunction

   function automatic logic [11:0] digits_of(input int v, input int k);
      logic [11:0] r = '0;
      int x = v;
      for (int i = 0; i < ndig[k]; i++) begin
         r[4*i +: 4] = 4'(x % radix[k]);
         x = x / radix[k];
      end
      return r;
   endfunction

   function automatic int value_of(input logic [11:0] l, input int k);
      int v = 0;
      for (int i = ndig[k] - 1; i >= 0; i--) begin
         int d = int'(l[4*i +: 4]);
         if (d >= radix[k]) d = radix[k] - 1;
         v = v * radix[k] + d;
      end
      return v;
   endfunction

   function automatic logic [20:0] seg_exp(input logic [11:0] c, input int k);
      logic [20:0] s = '0;
      for (int i = 0; i < ndig[k]; i++) s[7*i +: 7] = SEG_TAB[c[4*i +: 4]];
      return s;
   endfunction

   task automatic model_edge();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         int n = modulus(k);
         logic dir_up;
`ifdef COUNT_DOWN_EN
         dir_up = up;
`else
         dir_up = 1'b1;
`endif
         mtick[k] = 1'b0;
         mwrap[k] = 1'b0;
         if (reset) begin
            val[k] = 0; phase[k] = 0; interval[k] = int'(period);
         end else if (load) begin
            val[k] = value_of(lv, k); phase[k] = 0; interval[k] = int'(period);
         end else if (enable) begin
            phase[k]++;
            if (phase[k] == interval[k] + 1) begin
               phase[k] = 0;
               interval[k] = int'(period);
               mtick[k] = 1'b1;
               if (dir_up) begin
                  mwrap[k] = (val[k] == n - 1);
                  val[k] = (val[k] + 1) % n;
               end else begin
                  mwrap[k] = (val[k] == 0);
                  val[k] = (val[k] + n - 1) % n;
               end
            end
         end
      end
      e.c0 = digits_of(val[0], 0); e.t0 = mtick[0]; e.w0 = mwrap[0];
      e.c1 = digits_of(val[1], 1); e.t1 = mtick[1]; e.w1 = mwrap[1];
      exp_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_edge();
   end

   // Monitor: the counter presents a new output every cycle; pop and compare mid-cycle.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("count0", count0, e.c0);
         check("tick0", tick0, e.t0);
         check("wrap0", wrap0, e.w0);
         check("seg0", seg0, seg_exp(e.c0, 0));
         check("count1", count1, e.c1);
         check("tick1", tick1, e.t1);
         check("wrap1", wrap1, e.w1);
         check("seg1", seg1, seg_exp(e.c1, 1));
      end
   end

   int n;

   initial begin
      enable = 1'b1; up = 1'b1; period = 8'd3; reset = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_count0", count0, 8'h00);
      check("reset_seg0", seg0, 14'b0000001_0000001);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("first_step_count0", count0, 8'h01);
      repeat (396) @(negedge clk);
      check("hundred_steps_count0", count0, 8'h00);
      check("hundred_steps_count1", count1, 12'h064);

      lv = 12'h03C; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("clamp_count0", count0, 8'h39);
      check("clamp_count1", count1, 12'h03C);

      period = 8'd0; lv = 12'hFFF; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("load_ff_count1", count1, 12'hFFF);
      @(negedge clk);
      check("wrap_count1", count1, 12'h000);
      check("wrap_flag1", wrap1, 1'b1);
      check("wrap_tick1", tick1, 1'b1);
      check("wrap_seg1", seg1, 21'b0000001_0000001_0000001);
      check("wrap_flag0", wrap0, 1'b1);

      lv = 12'h000; up = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
`ifdef COUNT_DOWN_EN
      check("down_first_count0", count0, 8'h99);
      check("down_first_wrap0", wrap0, 1'b1);
      @(negedge clk);
      check("down_second_count0", count0, 8'h98);
      check("down_second_wrap0", wrap0, 1'b0);
`else
      check("up_only_first_count0", count0, 8'h01);
      @(negedge clk);
      check("up_only_second_count0", count0, 8'h02);
`endif

      up = 1'b1; period = 8'd5; lv = 12'h000; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      n = 0;
      repeat (2) begin @(negedge clk); n++; end
      enable = 1'b0;
      repeat (3) begin @(negedge clk); n++; end
      enable = 1'b1;
      while (tick0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("stretched_interval", n, 9);

      period = 8'd0; lv = 12'h042; load = 1'b1;
      @(negedge clk);
      lv = 12'h017;
      @(negedge clk);
      load = 1'b0;
      check("load_on_step_count0", count0, 8'h17);
      check("load_on_step_tick0", tick0, 1'b0);

      repeat (3000) begin
         @(negedge clk);
         reset  = ($urandom_range(99) == 0);
         load   = ($urandom_range(19) == 0);
         enable = ($urandom_range(4) != 0);
         up     = 1'($urandom_range(1));
         if ($urandom_range(49) == 0) period = 8'($urandom_range(7));
         lv = 12'($urandom);
      end
      reset = 1'b0; load = 1'b0;
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
